// File: rtl/db_dram_arb_if.sv
// Bundle of the two requester ports, the DRAM PHY command/return port and the
// arbiter status outputs. The arbiter takes the slave view; the environment
// (requesters + PHY) takes the master view.
`timescale 1ns/1ps
interface db_dram_arb_if #(
  parameter int unsigned RAM_ADDR        = 22,
  parameter int unsigned RAM_DWIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 8
);
  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING) + 1;

  // Port 0 (lookup path)
  logic                  p0_req;
  logic                  p0_we;
  logic [RAM_ADDR-1:0]   p0_addr;
  logic [RAM_DWIDTH-1:0] p0_wdata;
  logic                  p0_gnt;
  logic [RAM_DWIDTH-1:0] p0_rd_dout;
  logic                  p0_rd_valid;

  // Port 1 (aging sweeper)
  logic                  p1_req;
  logic                  p1_we;
  logic [RAM_ADDR-1:0]   p1_addr;
  logic [RAM_DWIDTH-1:0] p1_wdata;
  logic                  p1_gnt;
  logic [RAM_DWIDTH-1:0] p1_rd_dout;
  logic                  p1_rd_valid;

  // DRAM PHY
  logic                  dram_wr_en;
  logic                  dram_rd_en;
  logic [RAM_ADDR-1:0]   dram_addr;
  logic [RAM_DWIDTH-1:0] dram_wr_din;
  logic [RAM_DWIDTH-1:0] dram_rd_dout;
  logic                  dram_rd_valid;

  // Status
  logic [CntW-1:0]       outstanding;
  logic                  err_orphan;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    output p0_gnt, p0_rd_dout, p0_rd_valid,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    output p1_gnt, p1_rd_dout, p1_rd_valid,
    output dram_wr_en, dram_rd_en, dram_addr, dram_wr_din,
    input  dram_rd_dout, dram_rd_valid,
    output outstanding, err_orphan
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    input  p0_gnt, p0_rd_dout, p0_rd_valid,
    output p1_req, p1_we, p1_addr, p1_wdata,
    input  p1_gnt, p1_rd_dout, p1_rd_valid,
    input  dram_wr_en, dram_rd_en, dram_addr, dram_wr_din,
    output dram_rd_dout, dram_rd_valid,
    input  outstanding, err_orphan
  );
endinterface

// File: rtl/db_dram_arb.sv
// Two-port DRAM command arbiter. Port 0 has default priority; port 1 is
// promoted after STARVE_LIMIT consecutive denied cycles. Granted reads record
// their owner in an in-order FIFO so PHY returns are routed back correctly.
`timescale 1ns/1ps
module db_dram_arb #(
  parameter int unsigned RAM_ADDR        = 22,
  parameter int unsigned RAM_DWIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 8,
  parameter int unsigned STARVE_LIMIT    = 4
) (
  input logic          clk,
  input logic          rst,
  db_dram_arb_if.slave bus
);
  localparam int unsigned PtrW = $clog2(MAX_OUTSTANDING);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [3:0]      StarveMax = 4'(STARVE_LIMIT);
  localparam logic [CntW-1:0] OutMax    = CntW'(MAX_OUTSTANDING);

  logic [3:0]                 starve_q, starve_d;
  logic [MAX_OUTSTANDING-1:0] owner_q;
  logic [PtrW-1:0]            wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]            out_q, out_d;
  logic                       rd_en_q, wr_en_q;
  logic [RAM_ADDR-1:0]        addr_q;
  logic [RAM_DWIDTH-1:0]      wdata_q, rd_dout_q;
  logic                       p0_rv_q, p1_rv_q, err_q;

  logic rd_ok, p0_elig, p1_elig, p0_gnt, p1_gnt;
  logic push, pop, orphan, pop_owner, wr_gnt;

  // Arbitration, FIFO bookkeeping and starvation counter next state.
  always_comb begin
    // Credits come only from registered state; a same-cycle pop does not free a slot.
    rd_ok     = out_q < OutMax;
    p0_elig   = bus.p0_req & (bus.p0_we | rd_ok);
    p1_elig   = bus.p1_req & (bus.p1_we | rd_ok);
    p1_gnt    = ~rst & p1_elig & ((starve_q == StarveMax) | ~p0_elig);
    p0_gnt    = ~rst & p0_elig & ~p1_gnt;
    push      = (p0_gnt & ~bus.p0_we) | (p1_gnt & ~bus.p1_we);
    wr_gnt    = (p0_gnt & bus.p0_we) | (p1_gnt & bus.p1_we);
    pop       = bus.dram_rd_valid & (out_q != '0);
    orphan    = bus.dram_rd_valid & (out_q == '0);
    pop_owner = owner_q[rd_ptr_q];
    out_d     = out_q + CntW'(push) - CntW'(pop);
    starve_d  = starve_q;
    if (!bus.p1_req || p1_gnt) begin
      starve_d = '0;
    end else if (starve_q < StarveMax) begin
      starve_d = starve_q + 4'd1;
    end
  end

  // All state and registered outputs; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q  <= '0;
      owner_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      out_q     <= '0;
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_dout_q <= '0;
      p0_rv_q   <= 1'b0;
      p1_rv_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      starve_q <= starve_d;
      out_q    <= out_d;
      if (push) begin
        owner_q[wr_ptr_q] <= p1_gnt;
        wr_ptr_q          <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q  <= rd_ptr_q + PtrW'(1);
        rd_dout_q <= bus.dram_rd_dout;
      end
      rd_en_q <= push;
      wr_en_q <= wr_gnt;
      // Address/data hold their last value while idle.
      if (p0_gnt || p1_gnt) begin
        addr_q  <= p1_gnt ? bus.p1_addr : bus.p0_addr;
        wdata_q <= p1_gnt ? bus.p1_wdata : bus.p0_wdata;
      end
      p0_rv_q <= pop & ~pop_owner;
      p1_rv_q <= pop & pop_owner;
      if (orphan) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.p0_gnt      = p0_gnt;
  assign bus.p1_gnt      = p1_gnt;
  assign bus.p0_rd_dout  = rd_dout_q;
  assign bus.p1_rd_dout  = rd_dout_q;
  assign bus.p0_rd_valid = p0_rv_q;
  assign bus.p1_rd_valid = p1_rv_q;
  assign bus.dram_rd_en  = rd_en_q;
  assign bus.dram_wr_en  = wr_en_q;
  assign bus.dram_addr   = addr_q;
  assign bus.dram_wr_din = wdata_q;
  assign bus.outstanding = out_q;
  assign bus.err_orphan  = err_q;
endmodule

// File: tb/tb_db_dram_arb.sv
// Randomized bench for db_dram_arb: requester and PHY models drive the DUT, a
// reference model predicts grants, commands and returns into queues, and a
// separate monitor pops and compares whenever the DUT presents an output.
`timescale 1ns/1ps
module tb_db_dram_arb;
  localparam int unsigned AW = 22;
  localparam int unsigned DW = 32;
  localparam int unsigned MO = 8;
  localparam int unsigned SL = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  db_dram_arb_if #(.RAM_ADDR(AW), .RAM_DWIDTH(DW), .MAX_OUTSTANDING(MO)) bus ();
  db_dram_arb #(.RAM_ADDR(AW), .RAM_DWIDTH(DW), .MAX_OUTSTANDING(MO), .STARVE_LIMIT(SL)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct { int stamp; logic we; logic [AW-1:0] addr; logic [DW-1:0] data; } cmd_t;
  typedef struct { int stamp; bit owner; logic [DW-1:0] data; } ret_t;

  cmd_t cmdq[$];
  ret_t retq[$];
  bit   ownq[$];  // owners of reads in flight, oldest first
  int   phyq[$];  // cycle at which each pending PHY return is due

  int cyc = 0;
  int n_pass = 0;
  int n_chk = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Knobs set by the sequence process, read by the driver.
  int p0_rate = 0, p1_rate = 0, p0_we_pct = 0, p1_we_pct = 0;
  bit phy_hold = 0, inject_orphan = 0, fixed = 0;
  int rst_until = 4;

  // Written only by the driver/model.
  int m_starve = 0;
  bit m_orph = 0;
  int g0_cnt = 0, g1_cnt = 0;
  bit pend0 = 0, pend1 = 0;
  logic we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] data0, data1;

  // Written only by the monitor.
  logic [DW-1:0] last_p0_data = '0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
  endfunction

  // Requesters, PHY and reference model.
  initial begin : driver
    bit e0, e1, x0, x1, rd_ok, o;
    int due;
    cmd_t c;
    ret_t r;
    bus.p0_req = 0; bus.p0_we = 0; bus.p0_addr = '0; bus.p0_wdata = '0;
    bus.p1_req = 0; bus.p1_we = 0; bus.p1_addr = '0; bus.p1_wdata = '0;
    bus.dram_rd_valid = 0; bus.dram_rd_dout = '0;
    forever begin
      @(posedge clk); #1;
      rst = (cyc < rst_until);
      if (!pend0 && $urandom_range(99) < p0_rate) begin
        pend0 = 1; we0 = ($urandom_range(99) < p0_we_pct);
        addr0 = fixed ? AW'(32'h10) : AW'($urandom); data0 = $urandom;
      end
      if (!pend1 && $urandom_range(99) < p1_rate) begin
        pend1 = 1; we1 = ($urandom_range(99) < p1_we_pct);
        addr1 = AW'($urandom); data1 = $urandom;
      end
      bus.p0_req = pend0; bus.p0_we = we0; bus.p0_addr = addr0; bus.p0_wdata = data0;
      bus.p1_req = pend1; bus.p1_we = we1; bus.p1_addr = addr1; bus.p1_wdata = data1;
      bus.dram_rd_valid = 0; bus.dram_rd_dout = $urandom;
      if (!rst) begin
        if (!phy_hold && phyq.size() > 0 && phyq[0] <= cyc) begin
          void'(phyq.pop_front());
          bus.dram_rd_valid = 1;
          if (fixed) bus.dram_rd_dout = 32'hDEADBEEF;
        end else if (inject_orphan && ownq.size() == 0 && phyq.size() == 0) begin
          bus.dram_rd_valid = 1;
        end
      end

      @(negedge clk);
      // Expected grant from the arbitration rules.
      rd_ok = ownq.size() < MO;
      e0 = pend0 && (we0 || rd_ok);
      e1 = pend1 && (we1 || rd_ok);
      x1 = !rst && e1 && (m_starve == SL || !e0);
      x0 = !rst && e0 && !x1;
      chk("gnt", 64'({bus.p1_gnt, bus.p0_gnt}), 64'({x1, x0}));

      if (!rst && bus.dram_rd_en) begin
        due = cyc + (fixed ? 3 : int'($urandom_range(4, 1)));
        if (phyq.size() > 0 && due <= phyq[$]) due = phyq[$] + 1;
        phyq.push_back(due);
      end

      if (rst) begin
        ownq.delete(); phyq.delete(); m_starve = 0; m_orph = 0;
      end else begin
        if (bus.dram_rd_valid) begin
          if (ownq.size() > 0) begin
            o = ownq.pop_front();
            r.stamp = cyc + 1; r.owner = o; r.data = bus.dram_rd_dout;
            retq.push_back(r);
          end else begin
            m_orph = 1;
          end
        end
        if (!bus.p1_req || x1) m_starve = 0;
        else if (m_starve < SL) m_starve++;
        if (x0) begin
          c.stamp = cyc + 1; c.we = we0; c.addr = addr0; c.data = data0; cmdq.push_back(c);
          if (!we0) ownq.push_back(1'b0);
          pend0 = 0; g0_cnt++;
        end
        if (x1) begin
          c.stamp = cyc + 1; c.we = we1; c.addr = addr1; c.data = data1; cmdq.push_back(c);
          if (!we1) ownq.push_back(1'b1);
          pend1 = 0; g1_cnt++;
        end
      end
    end
  end

  // Monitor: compares every registered DUT output against the scoreboard.
  initial begin : monitor
    cmd_t c;
    ret_t r;
    logic [DW-1:0] d;
    forever begin
      @(posedge clk); #3;
      chk("outstanding", 64'(bus.outstanding), 64'(ownq.size()));
      chk("err_orphan", 64'(bus.err_orphan), 64'(m_orph));
      if (bus.dram_rd_en || bus.dram_wr_en) begin
        if (cmdq.size() == 0) begin
          chk("cmd_unexpected", 64'({bus.dram_wr_en, bus.dram_rd_en}), 64'(0));
        end else begin
          c = cmdq.pop_front();
          chk("cmd_cycle", 64'(cyc), 64'(c.stamp));
          chk("cmd_kind", 64'({bus.dram_wr_en, bus.dram_rd_en}), 64'({c.we, !c.we}));
          chk("cmd_addr", 64'(bus.dram_addr), 64'(c.addr));
          if (c.we) chk("cmd_wdata", 64'(bus.dram_wr_din), 64'(c.data));
        end
      end else if (cmdq.size() > 0 && cmdq[0].stamp <= cyc) begin
        c = cmdq.pop_front();
        chk("cmd_missing", 64'({bus.dram_wr_en, bus.dram_rd_en}), 64'({c.we, !c.we}));
      end
      if (bus.p0_rd_valid || bus.p1_rd_valid) begin
        if (retq.size() == 0) begin
          chk("ret_unexpected", 64'({bus.p1_rd_valid, bus.p0_rd_valid}), 64'(0));
        end else begin
          r = retq.pop_front();
          chk("ret_cycle", 64'(cyc), 64'(r.stamp));
          chk("ret_owner", 64'({bus.p1_rd_valid, bus.p0_rd_valid}), 64'(r.owner ? 2'b10 : 2'b01));
          d = r.owner ? bus.p1_rd_dout : bus.p0_rd_dout;
          chk("ret_data", 64'(d), 64'(r.data));
          if (!r.owner) last_p0_data = d;
        end
      end else if (retq.size() > 0 && retq[0].stamp <= cyc) begin
        r = retq.pop_front();
        chk("ret_missing", 64'({bus.p1_rd_valid, bus.p0_rd_valid}), 64'(r.owner ? 2'b10 : 2'b01));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic drain();
    p0_rate = 0; p1_rate = 0; phy_hold = 0;
    for (int i = 0; i < 200 && (pend0 || pend1 || ownq.size() > 0 || phyq.size() > 0); i++) step(1);
    step(4);
    chk("drained", 64'({pend0, pend1, ownq.size() == 0, cmdq.size() == 0, retq.size() == 0}),
        64'(5'b00111));
  endtask

  // Directed scenarios followed by a random phase.
  initial begin : seq
    int s0, s1;
    step(6);

    // Single p0 read to 0x10, PHY answers 0xDEADBEEF three cycles later.
    fixed = 1; p0_we_pct = 0; p0_rate = 100;
    step(1);
    p0_rate = 0;
    step(12);
    chk("single_p0_data", 64'(last_p0_data), 64'(32'hDEADBEEF));
    fixed = 0;

    // Starvation: both ports writing continuously, p1 wins one cycle in five.
    p0_we_pct = 100; p1_we_pct = 100; p0_rate = 100; p1_rate = 100;
    step(3);
    s0 = g0_cnt; s1 = g1_cnt;
    step(20);
    chk("starve_p1_grants", 64'(g1_cnt - s1), 64'(4));
    chk("starve_p0_grants", 64'(g0_cnt - s0), 64'(16));
    drain();

    // FIFO full: reads stall at MAX_OUTSTANDING, writes still pass.
    phy_hold = 1; p0_we_pct = 0; p0_rate = 100;
    for (int i = 0; i < 40 && ownq.size() < MO; i++) step(1);
    step(2);
    chk("full_outstanding", 64'(bus.outstanding), 64'(MO));
    s0 = g0_cnt; s1 = g1_cnt;
    p1_we_pct = 100; p1_rate = 100;
    step(1);
    p1_rate = 0;
    step(3);
    chk("full_p0_stalled", 64'(g0_cnt), 64'(s0));
    chk("full_p1_write", 64'(g1_cnt - s1), 64'(1));
    phy_hold = 0;
    step(10);
    drain();

    // Orphan return sets the sticky error.
    inject_orphan = 1;
    for (int i = 0; i < 10 && !m_orph; i++) step(1);
    inject_orphan = 0;
    step(2);
    chk("orphan_set", 64'(bus.err_orphan), 64'(1));
    step(5);
    chk("orphan_sticky", 64'(bus.err_orphan), 64'(1));

    // Reset with five reads in flight and port 1 starving.
    phy_hold = 1; p0_we_pct = 0; p0_rate = 100;
    step(5);
    p0_rate = 0;
    step(2);
    chk("pre_reset_outstanding", 64'(bus.outstanding), 64'(5));
    p0_we_pct = 100; p1_we_pct = 0; p0_rate = 100; p1_rate = 100;
    for (int i = 0; i < 20 && m_starve != 2; i++) step(1);
    rst_until = cyc + 2;
    @(posedge clk); @(posedge clk); #4;
    chk("rst_outputs", 64'({bus.dram_rd_en, bus.dram_wr_en, bus.p0_rd_valid, bus.p1_rd_valid,
                            bus.err_orphan}), 64'(0));
    chk("rst_outstanding", 64'(bus.outstanding), 64'(0));
    chk("rst_buses", 64'(bus.dram_addr | bus.dram_wr_din | bus.p0_rd_dout), 64'(0));
    step(3);
    drain();

    // Random traffic with PHY back-pressure and one reset.
    p0_rate = 40; p1_rate = 40; p0_we_pct = 40; p1_we_pct = 40;
    for (int i = 0; i < 600; i++) begin
      step(1);
      if ($urandom_range(19) == 0) phy_hold = !phy_hold;
      if (i == 300) rst_until = cyc + 2;
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/db_dram_arb.md
# db_dram_arb

Two-port arbiter that shares the single DRAM PHY command port between the lookup path (`db_cont`, port 0) and the entry-aging sweeper (port 1). It issues at most one read or write per cycle and tracks outstanding reads in an in-order owner FIFO. It routes each read return back to the requester that issued it. It sits between `db_cont`/sweeper and `dram_phy` inside `db_top`.

## Interface
Parameters:
- `RAM_ADDR`, 22, DRAM word address width
- `RAM_DWIDTH`, 32, DRAM data width
- `MAX_OUTSTANDING`, 8, owner-FIFO depth (power of two, ≥2); max reads in flight
- `STARVE_LIMIT`, 4, consecutive denied cycles after which port 1 takes priority (1..15)

Ports:
- `clk` in 1, sole clock
- `rst` in 1, synchronous, active-high reset
- `p0_req` in 1, port-0 command request
- `p0_we` in 1, 1 = write, 0 = read
- `p0_addr` in RAM_ADDR, command address
- `p0_wdata` in RAM_DWIDTH, write data
- `p0_gnt` out 1, command accepted this cycle
- `p0_rd_dout` out RAM_DWIDTH, read return data
- `p0_rd_valid` out 1, read return strobe
- `p1_*`: same seven signals for port 1
- `dram_wr_en` out 1, write strobe to PHY
- `dram_rd_en` out 1, read strobe to PHY
- `dram_addr` out RAM_ADDR, PHY address
- `dram_wr_din` out RAM_DWIDTH, PHY write data
- `dram_rd_dout` in RAM_DWIDTH, PHY read data
- `dram_rd_valid` in 1, PHY read return strobe; returns are in issue order
- `outstanding` out log2(MAX_OUTSTANDING)+1, reads in flight
- `err_orphan` out 1, sticky: a return arrived with the owner FIFO empty

## Operation
- Eligibility: a port is eligible when `req`=1 and either it is a write, or it is a read and `outstanding < MAX_OUTSTANDING`. Same-cycle pops are not credited.
- Priority: port 0 wins by default. Port 1 wins when `starve_cnt == STARVE_LIMIT`. An ineligible port never wins. At most one `gnt` is high per cycle.
- `gnt` is combinational from the current `req`/`we` and registered state. The requester must hold `req`, `we`, `addr` and `wdata` stable until it sees `gnt`.
- `starve_cnt` (saturating at STARVE_LIMIT):
  - clears on `p1_gnt` or when `p1_req`=0;
  - otherwise increments while `p1_req`=1 and `p1_gnt`=0, including when port 1 is ineligible.
- Granted read: push the owner bit (0/1) into the FIFO and increment `outstanding`.
- `dram_rd_valid`: pop the FIFO head and route the data to that owner. Push and pop in the same cycle leave `outstanding` unchanged.
- Orphan return: `dram_rd_valid` with the FIFO empty drops the data and sets `err_orphan`. Only `rst` clears `err_orphan`.
- `dram_phy` shares `rst`, so no returns for pre-reset reads arrive after reset.

## Timing
- Command latency: grant in cycle T puts `dram_rd_en` or `dram_wr_en`, `dram_addr` and `dram_wr_din` out, registered, in cycle T+1.
  - Strobes are single-cycle pulses.
  - `dram_addr`/`dram_wr_din` hold their last value when idle.
- Return latency: `dram_rd_valid` in cycle T gives `pX_rd_valid`=1 and `pX_rd_dout`=`dram_rd_dout` for the owner in cycle T+1.
  - The other port's `rd_valid` stays 0.
  - Both `rd_dout` buses may carry the data.
- Throughput: one command per cycle, back-to-back grants allowed. Reads stall at `outstanding == MAX_OUTSTANDING` until a pop is registered; writes proceed.
- Reset (synchronous, any cycle, including mid-burst):
  - all outputs are 0;
  - `starve_cnt`=0, FIFO empty, `outstanding`=0;
  - in-flight reads are discarded;
  - no `gnt` is issued in the reset cycle.
- Simultaneous `p0_req` and `p1_req` with both eligible and `starve_cnt < STARVE_LIMIT`: port 0 is granted.

## Test plan
- Single port: p0 read at addr 0x000010; PHY returns 0xDEADBEEF 3 cycles after `dram_rd_en` → `dram_rd_en` at T+1 with `dram_addr`=0x10; `p0_rd_valid` one cycle after `dram_rd_valid` with data 0xDEADBEEF; `p1_rd_valid` stays 0.
- Starvation: p0 and p1 request continuously, STARVE_LIMIT=4 → p1 is granted on every 5th cycle (4 denials then a grant); the pattern repeats.
- Interleaved ownership: alternate grants p0 read A, p1 read B, p0 read C; PHY returns in order → returns route p0, p1, p0 with matching data; `outstanding` goes 0→3→0.
- FIFO full: 8 p0 reads with no returns → `outstanding`=8, further p0 reads not granted, a p1 write is still granted. One return → the next p0 read is granted one cycle later.
- Orphan and same-cycle push/pop: `dram_rd_valid` with `outstanding`=0 → `err_orphan`=1 and stays 1, no `rd_valid` on either port. A grant and a return in the same cycle → `outstanding` unchanged.
- Reset mid-operation: assert `rst` with 5 reads outstanding and `starve_cnt`=3 → next cycle all outputs 0, `outstanding`=0, `err_orphan`=0. After reset the first simultaneous request grants p0.
